seq_signed_mac: RTL and testbench



---
 rtl/seq_mac_pkg.sv | 16 +
 rtl/seq_mult_core.sv | 86 ++++++++
 rtl/seq_signed_mac.sv | 71 +++++++
 tb/tb_seq_signed_mac.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mac_pkg.sv
// Shared types and helpers for the sequential signed multiply-accumulate block.
package seq_mac_pkg;

    // Multiplier control states: wait for operands, shift-add one bit per cycle, publish.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the bit-position counter that walks the multiplier.
    function automatic int cnt_bits(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/seq_mult_core.sv
// Handshake, control FSM and shift-add datapath of a two's-complement multiplier.
// One multiplier bit is consumed per RUN cycle; the sign bit carries negative weight.
module seq_mult_core
    import seq_mac_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 accumulate,
    output logic [2*WIDTH-1:0]   partial,
    output logic                 acc_flag,
    output logic                 done
);

    localparam int             CW   = cnt_bits(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t               state;
    state_t               state_nxt;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   mcand;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   addend;

    assign in_ready = (state == IDLE) && !rst;
    assign done     = (state == DONE);
    assign addend   = mcand << cnt;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture and shift-add accumulation of the partial product.
    always_ff @(posedge clk) begin
        // NOTE: datapath registers are reset too so an aborted operation leaves nothing stale behind.
        if (rst) begin
            mplier   <= '0;
            mcand    <= '0;
            cnt      <= '0;
            partial  <= '0;
            acc_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mplier   <= multiplier;
                        mcand    <= {{WIDTH{multiplicand[WIDTH-1]}}, multiplicand};
                        acc_flag <= accumulate;
                        partial  <= '0;
                        cnt      <= '0;
                    end
                end
                RUN: begin
                    if (mplier[cnt]) begin
                        // The top multiplier bit weighs -2^(WIDTH-1), so it subtracts.
                        if (cnt == LAST) partial <= partial - addend;
                        else             partial <= partial + addend;
                    end
                    cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/seq_signed_mac.sv
// Sequential signed multiply-accumulate: wraps the shift-add multiplier with a
// running accumulator, sticky signed-overflow flag and synchronous clear.
module seq_signed_mac
    import seq_mac_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 2*WIDTH + 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       multiplicand,
    input  logic [WIDTH-1:0]       multiplier,
    input  logic                   accumulate,
    input  logic                   clear_acc,
    output logic                   out_valid,
    output logic [2*WIDTH-1:0]     product,
    output logic [ACC_WIDTH-1:0]   acc_out,
    output logic                   overflow
);

    logic [2*WIDTH-1:0]    partial;
    logic                  acc_flag;
    logic                  done;
    logic [ACC_WIDTH-1:0]  prod_ext;
    logic [ACC_WIDTH-1:0]  acc_base;
    logic [ACC_WIDTH-1:0]  acc_sum;
    logic                  ovf_now;

    seq_mult_core #(.WIDTH(WIDTH)) u_core (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .accumulate   (accumulate),
        .partial      (partial),
        .acc_flag     (acc_flag),
        .done         (done)
    );

    // A clear coinciding with completion wins over the accumulate request: clear first, then add.
    assign prod_ext = ACC_WIDTH'($signed(partial));
    assign acc_base = (acc_flag && !clear_acc) ? acc_out : '0;
    assign acc_sum  = acc_base + prod_ext;
    assign ovf_now  = (acc_base[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                      (acc_sum[ACC_WIDTH-1]  != acc_base[ACC_WIDTH-1]);

    // Result publication, accumulator update, sticky overflow and clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            product   <= '0;
            acc_out   <= '0;
            overflow  <= 1'b0;
        end else begin
            out_valid <= done;
            if (done) begin
                product  <= partial;
                acc_out  <= acc_sum;
                overflow <= (overflow && !clear_acc) || ovf_now;
            end else if (clear_acc) begin
                acc_out  <= '0;
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_signed_mac.sv
// Scoreboard bench for seq_signed_mac: a WIDTH=8/ACC_WIDTH=16 instance for directed
// and overflow vectors, and a WIDTH=4 instance swept over all operand pairs.
module tb_seq_signed_mac;

    localparam int W8 = 8;
    localparam int A8 = 16;
    localparam int W4 = 4;
    localparam int A4 = 2*W4 + 8;

    typedef logic signed [63:0] val_t;
    typedef struct {
        val_t prod;
        val_t acc;
        logic ovf;
        int   edge_acc;
        bit   b2b;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic             in_valid8, in_ready8, accum8, clr8, out_valid8, ovf8;
    logic [W8-1:0]    a8, b8;
    logic [2*W8-1:0]  product8;
    logic [A8-1:0]    acc8;

    logic             in_valid4, in_ready4, accum4, clr4, out_valid4, ovf4;
    logic [W4-1:0]    a4, b4;
    logic [2*W4-1:0]  product4;
    logic [A4-1:0]    acc4;

    seq_signed_mac #(.WIDTH(W8), .ACC_WIDTH(A8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .multiplicand(a8), .multiplier(b8), .accumulate(accum8), .clear_acc(clr8),
        .out_valid(out_valid8), .product(product8), .acc_out(acc8), .overflow(ovf8)
    );

    seq_signed_mac #(.WIDTH(W4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .multiplicand(a4), .multiplier(b4), .accumulate(accum4), .clear_acc(clr4),
        .out_valid(out_valid4), .product(product4), .acc_out(acc4), .overflow(ovf4)
    );

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q8[$];
    exp_t q4[$];
    exp_t m8, m4;
    int   last_out8 = -1000;
    int   last_out4 = -1000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input val_t actual, input val_t expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (edge %0d)", name, cyc);
    endtask

    // Monitor for the WIDTH=8 instance.
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid8 === 1'b1) begin
            if (q8.size() == 0) fail_now("out8_unexpected");
            else begin
                m8 = q8.pop_front();
                check("prod8", val_t'($signed(product8)), m8.prod);
                check("acc8", val_t'($signed(acc8)), m8.acc);
                check("ovf8", val_t'(ovf8), val_t'(m8.ovf));
                check("latency8", val_t'(cyc - m8.edge_acc), val_t'(W8 + 1));
                if (m8.b2b) check("spacing8", val_t'(cyc - last_out8), val_t'(W8 + 2));
                last_out8 = cyc;
            end
        end
    end

    // Monitor for the WIDTH=4 instance.
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid4 === 1'b1) begin
            if (q4.size() == 0) fail_now("out4_unexpected");
            else begin
                m4 = q4.pop_front();
                check("prod4", val_t'($signed(product4)), m4.prod);
                check("acc4", val_t'($signed(acc4)), m4.acc);
                check("ovf4", val_t'(ovf4), val_t'(m4.ovf));
                check("latency4", val_t'(cyc - m4.edge_acc), val_t'(W4 + 1));
                if (m4.b2b) check("spacing4", val_t'(cyc - last_out4), val_t'(W4 + 2));
                last_out4 = cyc;
            end
        end
    end

    task automatic issue8(input int a, input int b, input logic acc, input val_t ep,
                          input val_t ea, input logic eo, input bit b2b, input bit push,
                          output int edge_id);
        int guard;
        exp_t e;
        @(negedge clk);
        a8 = a[W8-1:0];
        b8 = b[W8-1:0];
        accum8 = acc;
        in_valid8 = 1'b1;
        guard = 0;
        while (in_ready8 !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) fail_now("accept8_timeout");
        @(posedge clk);
        #1;
        edge_id = cyc;
        if (push) begin
            e.prod = ep; e.acc = ea; e.ovf = eo; e.edge_acc = edge_id; e.b2b = b2b;
            q8.push_back(e);
        end
    endtask

    task automatic issue4(input int a, input int b, input val_t ep, input bit b2b);
        int guard;
        exp_t e;
        @(negedge clk);
        a4 = a[W4-1:0];
        b4 = b[W4-1:0];
        accum4 = 1'b0;
        in_valid4 = 1'b1;
        guard = 0;
        while (in_ready4 !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) fail_now("accept4_timeout");
        @(posedge clk);
        #1;
        e.prod = ep; e.acc = ep; e.ovf = 1'b0; e.edge_acc = cyc; e.b2b = b2b;
        q4.push_back(e);
    endtask

    task automatic idle8();
        @(negedge clk);
        in_valid8 = 1'b0;
    endtask

    task automatic drain8();
        int guard = 0;
        while (q8.size() != 0 && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        if (q8.size() != 0) begin
            fail_now("drain8_timeout");
            q8.delete();
        end
    endtask

    task automatic drain4();
        int guard = 0;
        while (q4.size() != 0 && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        if (q4.size() != 0) begin
            fail_now("drain4_timeout");
            q4.delete();
        end
    endtask

    task automatic pulse_clear8();
        @(negedge clk);
        clr8 = 1'b1;
        @(negedge clk);
        clr8 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        int seen;
        int ca[4] = '{0, -128, 127, -1};
        int cb[4] = '{-128, -128, -128, 127};
        int cp[4] = '{0, 16384, -16256, -127};
        int ma[3] = '{10, -3, -128};
        int mb[3] = '{10, 7, 127};
        int mp[3] = '{100, -21, -16256};
        int macc_v[3] = '{100, 79, -16177};
        logic signed [A8-1:0] macc, base, ps, s;
        logic movf;
        int ra, rb;
        logic racc;

        rst = 1'b1;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; accum8 = 1'b0; clr8 = 1'b0;
        in_valid4 = 1'b0; a4 = '0; b4 = '0; accum4 = 1'b0; clr4 = 1'b0;

        // Reset values.
        repeat (2) @(negedge clk);
        check("ready_in_reset", val_t'(in_ready8), 0);
        check("valid_in_reset", val_t'(out_valid8), 0);
        check("prod_in_reset", val_t'(product8), 0);
        check("acc_in_reset", val_t'(acc8), 0);
        check("ovf_in_reset", val_t'(ovf8), 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", val_t'(in_ready8), 1);

        // Basic product and latency.
        issue8(3, 5, 1'b0, 15, 15, 1'b0, 1'b0, 1'b1, e);
        idle8();
        drain8();

        // Signed corners, load mode.
        for (int i = 0; i < 4; i++) begin
            issue8(ca[i], cb[i], 1'b0, cp[i], cp[i], 1'b0, 1'b0, 1'b1, e);
            idle8();
            drain8();
        end

        // Clear in IDLE.
        pulse_clear8();
        check("clear_idle_acc", val_t'($signed(acc8)), 0);
        check("clear_idle_ovf", val_t'(ovf8), 0);

        // Multiply-accumulate chain.
        for (int i = 0; i < 3; i++) begin
            issue8(ma[i], mb[i], 1'b1, mp[i], macc_v[i], 1'b0, 1'b0, 1'b1, e);
            idle8();
            drain8();
        end

        // Accumulator wrap and sticky overflow, then clear coincident with DONE.
        pulse_clear8();
        issue8(-128, -128, 1'b1, 16384, 16384, 1'b0, 1'b0, 1'b1, e);
        idle8();
        drain8();
        issue8(-128, -128, 1'b1, 16384, -32768, 1'b1, 1'b0, 1'b1, e);
        idle8();
        drain8();
        issue8(-128, -128, 1'b1, 16384, 16384, 1'b0, 1'b0, 1'b1, e);
        idle8();
        while (cyc < e + W8) @(negedge clk);
        clr8 = 1'b1;
        @(negedge clk);
        clr8 = 1'b0;
        drain8();

        // Clear during RUN, then accumulate onto the cleared value.
        issue8(-1, -1, 1'b1, 1, 1, 1'b0, 1'b0, 1'b1, e);
        idle8();
        clr8 = 1'b1;
        @(negedge clk);
        clr8 = 1'b0;
        check("clear_run_acc", val_t'($signed(acc8)), 0);
        drain8();

        // Reset while RUN at cnt=3 aborts the operation.
        issue8(50, 50, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, e);
        idle8();
        while (cyc < e + 3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_acc", val_t'($signed(acc8)), 0);
        check("abort_prod", val_t'($signed(product8)), 0);
        @(negedge clk);
        check("abort_ready", val_t'(in_ready8), 1);
        seen = 0;
        repeat (W8 + 4) begin
            @(negedge clk);
            if (out_valid8 !== 1'b0) seen++;
        end
        check("abort_no_out_valid", val_t'(seen), 0);
        issue8(2, -2, 1'b0, -4, -4, 1'b0, 1'b0, 1'b1, e);
        idle8();
        drain8();

        // Back-to-back random pairs with in_valid held; operands change during RUN.
        macc = -16'sd4;
        movf = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ra = int'($urandom_range(0, 255)) - 128;
            rb = int'($urandom_range(0, 255)) - 128;
            racc = 1'($urandom_range(0, 1));
            ps = A8'(ra * rb);
            base = racc ? macc : '0;
            s = base + ps;
            if (base[A8-1] == ps[A8-1] && s[A8-1] != base[A8-1]) movf = 1'b1;
            macc = s;
            issue8(ra, rb, racc, val_t'(ra * rb), val_t'(s), movf, i > 0, 1'b1, e);
        end
        idle8();
        drain8();

        // WIDTH=4: every operand pair, back to back.
        for (int a = -8; a < 8; a++) begin
            for (int b = -8; b < 8; b++) begin
                issue4(a, b, val_t'(a * b), !(a == -8 && b == -8));
            end
        end
        @(negedge clk);
        in_valid4 = 1'b0;
        drain4();

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
